// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 64;

  // Arbiter sequencing states: fetch wait, data wait, and the data release cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    D_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry fetch buffer: remembers the last fetched instruction so a fetch
// that already completed stays satisfied while the data side is served.
module mem_arb_ibuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inval_i,
  input  logic [ADDR_W-1:0] inval_addr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              ihit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Fill on fetch completion; drop the entry when a store overwrites its word.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (fill_i) begin
      r_valid <= 1'b1;
      r_addr  <= fill_addr_i;
      r_data  <= fill_data_i;
    end else if (inval_i && (inval_addr_i == r_addr)) begin
      r_valid <= 1'b0;
    end
  end

  assign ihit_o = r_valid & (r_addr == lookup_addr_i);
  assign data_o = r_data;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data
// access. Fetch wins ties; a watchdog flags requests that wait too long.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_stall_o,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_MAX  = WDT_W'(TIMEOUT_CYC);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYC - 1);

  arb_state_t        r_state;
  logic              r_mem_req;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_err;
  logic [WDT_W-1:0]  r_wdt;

  logic              w_ihit;
  logic [DATA_W-1:0] w_ibuf_data;
  logic              w_fill;
  logic              w_inval;
  logic              w_wdt_run;

  // The buffer is filled from the registered fetch address, so the memory
  // ack only reaches outputs through flops.
  assign w_fill    = (r_state == I_WAIT) & mem_ack_i;
  assign w_inval   = (r_state == D_DONE) & r_mem_write;
  assign w_wdt_run = ((r_state == I_WAIT) | (r_state == D_WAIT)) & ~mem_ack_i;

  mem_arb_ibuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ibuf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fill_i       (w_fill),
    .fill_addr_i  (r_mem_addr),
    .fill_data_i  (mem_rdata_i),
    .inval_i      (w_inval),
    .inval_addr_i (r_mem_addr),
    .lookup_addr_i(i_addr_i),
    .ihit_o       (w_ihit),
    .data_o       (w_ibuf_data)
  );

  // Sequencer, request latches and watchdog; memory-side outputs are held
  // stable from issue until the ack.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
      r_wdt       <= '0;
    end else begin
      if (w_wdt_run && (r_wdt != WDT_MAX)) begin
        r_wdt <= r_wdt + 1'b1;
        if (r_wdt == WDT_LAST) begin
          r_err <= 1'b1;
        end
      end
      case (r_state)
        IDLE: begin
          if (i_req_i && !w_ihit) begin
            r_state     <= I_WAIT;
            r_mem_req   <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_addr_i;
            r_wdt       <= '0;
          end else if (d_req_i) begin
            r_state     <= D_WAIT;
            r_mem_req   <= 1'b1;
            r_mem_write <= d_write_i;
            r_mem_addr  <= d_addr_i;
            r_mem_wdata <= d_wdata_i;
            r_wdt       <= '0;
          end
        end
        I_WAIT: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        D_WAIT: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            if (!r_mem_write) begin
              r_d_rdata <= mem_rdata_i;
            end
            r_state <= D_DONE;
          end
        end
        D_DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i_stall_o   = i_req_i & ~w_ihit;
  assign d_stall_o   = d_req_i & (r_state != D_DONE);
  assign stall_o     = i_stall_o | d_stall_o;
  assign i_data_o    = w_ibuf_data;
  assign d_rdata_o   = r_d_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_data_o;
  logic          i_stall_o;
  logic          d_req_i;
  logic          d_write_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_stall_o;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          req_log[$];
  logic [DW-1:0] ifetch_q[$];
  logic [DW-1:0] dload_q[$];
  logic [DW-1:0] mem_model [bit [31:0]];
  int            ack_lat = 1;
  int            rcnt = 0;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] last_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_data_o   (i_data_o),
    .i_stall_o  (i_stall_o),
    .d_req_i    (d_req_i),
    .d_write_i  (d_write_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_stall_o  (d_stall_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o)
  );

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks once a request has been pending ack_lat cycles
  // (ack_lat == 0 means never ack); logs every newly issued request.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o === 1'b1) begin
        if (rcnt == 0) begin
          req_log.push_back('{wr: mem_write_o, addr: mem_addr_o, wdata: mem_wdata_o});
          iss_addr = mem_addr_o;
        end
        rcnt++;
        if (ack_lat != 0 && rcnt >= ack_lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o === 1'b1) begin
            mem_model[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = 32'hFFFF_FFFF;
          end else begin
            mem_rdata_i = mem_rd(mem_addr_o);
          end
          checks++;
          if (mem_addr_o !== iss_addr) begin
            errors++;
            $display("FAIL addr_stable: got %h expected %h", mem_addr_o, iss_addr);
          end
        end else begin
          mem_ack_i = 1'b0;
        end
      end else begin
        rcnt      = 0;
        mem_ack_i = 1'b0;
      end
    end
  end

  // Drive one set of requests at the next edge and hold them until stall_o
  // drops; returns at the negedge of the release cycle.
  task automatic run_access(input logic ireq, input logic [AW-1:0] iaddr,
                            input logic dreq, input logic dwr,
                            input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata,
                            output int st);
    @(posedge clk); #1;
    i_req_i   = ireq;
    i_addr_i  = iaddr;
    d_req_i   = dreq;
    d_write_i = dwr;
    d_addr_i  = daddr;
    d_wdata_i = dwdata;
    st = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      st++;
      if (st > 100) begin
        errors++;
        $display("FAIL release_timeout: got %0d stall cycles expected release", st);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_inputs();
    @(posedge clk); #1;
    i_req_i   = 1'b0;
    d_req_i   = 1'b0;
    d_write_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h10;
    d_req_i = 1'b0; d_write_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req_o); end
    checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b expected 0", mem_write_o); end
    checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== '0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata_o); end
    checks++; if (d_rdata_o !== '0) begin errors++; $display("FAIL rst_d_rdata: got %h expected 0", d_rdata_o); end
    checks++; if (i_data_o !== '0) begin errors++; $display("FAIL rst_i_data: got %h expected 0", i_data_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
    checks++; if (i_stall_o !== 1'b1) begin errors++; $display("FAIL rst_i_stall: got %b expected 1", i_stall_o); end
    checks++; if (d_stall_o !== 1'b0) begin errors++; $display("FAIL rst_d_stall: got %b expected 0", d_stall_o); end
    @(posedge clk); #1;
    rst_i = 1'b1; i_req_i = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_fetch_miss();
    int st;
    int n;
    logic [DW-1:0] exp;
    req_log.delete();
    ack_lat = 3;
    ifetch_q.push_back(32'h00A00093);
    run_access(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, st);
    exp = ifetch_q.pop_front();
    checks++; if (st != 4) begin errors++; $display("FAIL fetch_stall_len: got %0d expected 4", st); end
    checks++; if (i_data_o !== exp) begin errors++; $display("FAIL fetch_data: got %h expected %h", i_data_o, exp); end
    checks++; if (req_log.size() != 1 || req_log[0].addr !== 32'h10 || req_log[0].wr !== 1'b0) begin
      errors++; $display("FAIL fetch_mem_req: got n=%0d addr=%h wr=%b expected n=1 addr=10 wr=0",
                         req_log.size(), req_log[0].addr, req_log[0].wr); end
    $display("fetch 0x10: data=%h stall=%0d", i_data_o, st);
    n = req_log.size();
    ifetch_q.push_back(32'h00A00093);
    run_access(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, st);
    exp = ifetch_q.pop_front();
    checks++; if (st != 0) begin errors++; $display("FAIL refetch_stall: got %0d expected 0", st); end
    checks++; if (i_data_o !== exp) begin errors++; $display("FAIL refetch_data: got %h expected %h", i_data_o, exp); end
    repeat (2) @(negedge clk);
    checks++; if (req_log.size() != n) begin errors++; $display("FAIL refetch_no_req: got %0d requests expected %0d", req_log.size(), n); end
    $display("refetch 0x10: data=%h stall=%0d", i_data_o, st);
    idle_inputs();
  endtask

  task automatic test_collision();
    int st;
    logic [DW-1:0] exp_i, exp_d;
    req_log.delete();
    ack_lat = 2;
    ifetch_q.push_back(32'h00B00113);
    dload_q.push_back(32'h12345678);
    run_access(1'b1, 32'h14, 1'b1, 1'b0, 32'h100, '0, st);
    exp_i = ifetch_q.pop_front();
    exp_d = dload_q.pop_front();
    checks++; if (st != 6) begin errors++; $display("FAIL coll_stall_len: got %0d expected 6", st); end
    checks++; if (i_stall_o !== 1'b0 || d_stall_o !== 1'b0) begin
      errors++; $display("FAIL coll_release: got i=%b d=%b expected 0 0", i_stall_o, d_stall_o); end
    checks++; if (i_data_o !== exp_i) begin errors++; $display("FAIL coll_i_data: got %h expected %h", i_data_o, exp_i); end
    checks++; if (d_rdata_o !== exp_d) begin errors++; $display("FAIL coll_d_rdata: got %h expected %h", d_rdata_o, exp_d); end
    checks++; if (req_log.size() != 2 || req_log[0].addr !== 32'h14 || req_log[1].addr !== 32'h100 || req_log[1].wr !== 1'b0) begin
      errors++; $display("FAIL coll_order: got n=%0d first=%h second=%h expected n=2 first=14 second=100",
                         req_log.size(), req_log[0].addr, req_log[1].addr); end
    last_rdata = exp_d;
    $display("collision: i_data=%h d_rdata=%h stall=%0d", i_data_o, d_rdata_o, st);
    idle_inputs();
  endtask

  task automatic test_store_invalidate();
    int st;
    logic [DW-1:0] exp;
    req_log.delete();
    ack_lat = 1;
    ifetch_q.push_back(32'h00C00193);
    run_access(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, st);
    exp = ifetch_q.pop_front();
    checks++; if (i_data_o !== exp || st != 2) begin
      errors++; $display("FAIL fill_0x20: got %h/%0d expected %h/2", i_data_o, st, exp); end
    run_access(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, st);
    checks++; if (st != 2) begin errors++; $display("FAIL store_stall_len: got %0d expected 2", st); end
    checks++; if (i_stall_o !== 1'b0) begin errors++; $display("FAIL store_release_i: got %b expected 0", i_stall_o); end
    checks++; if (d_rdata_o !== last_rdata) begin errors++; $display("FAIL store_rdata_kept: got %h expected %h", d_rdata_o, last_rdata); end
    checks++; if (req_log.size() != 2 || req_log[1].wr !== 1'b1 || req_log[1].addr !== 32'h20 || req_log[1].wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_mem_req: got wr=%b addr=%h wdata=%h expected wr=1 addr=20 wdata=deadbeef",
                         req_log[1].wr, req_log[1].addr, req_log[1].wdata); end
    @(posedge clk); #1;
    d_req_i = 1'b0; d_write_i = 1'b0;
    @(negedge clk);
    checks++; if (i_stall_o !== 1'b1) begin errors++; $display("FAIL store_invalidate: got i_stall=%b expected 1", i_stall_o); end
    ifetch_q.push_back(32'hDEADBEEF);
    run_access(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, st);
    exp = ifetch_q.pop_front();
    checks++; if (i_data_o !== exp) begin errors++; $display("FAIL refetch_after_store: got %h expected %h", i_data_o, exp); end
    checks++; if (st != 1) begin errors++; $display("FAIL refetch_rest_stall: got %0d expected 1", st); end
    $display("store invalidate: refetch data=%h", i_data_o);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int st;
    logic [DW-1:0] exp;
    req_log.delete();
    ack_lat = 1;
    dload_q.push_back(32'h00A00093);
    dload_q.push_back(32'h12345678);
    run_access(1'b0, '0, 1'b1, 1'b0, 32'h10, '0, st);
    exp = dload_q.pop_front();
    checks++; if (st != 2 || d_rdata_o !== exp) begin
      errors++; $display("FAIL b2b_first: got %h/%0d expected %h/2", d_rdata_o, st, exp); end
    $display("b2b load 0x10: d_rdata=%h stall=%0d", d_rdata_o, st);
    run_access(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, st);
    exp = dload_q.pop_front();
    checks++; if (st != 2 || d_rdata_o !== exp) begin
      errors++; $display("FAIL b2b_second: got %h/%0d expected %h/2", d_rdata_o, st, exp); end
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL b2b_reqs: got %0d expected 2", req_log.size()); end
    last_rdata = exp;
    $display("b2b load 0x100: d_rdata=%h stall=%0d", d_rdata_o, st);
    idle_inputs();
  endtask

  task automatic test_timeout();
    int st;
    logic [DW-1:0] exp;
    req_log.delete();
    ack_lat = 0;
    dload_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    d_req_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h200;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 8) begin
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", err_o); end
      end
      if (c == 9) begin
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err_o); end
      end
      if (c == 12) begin
        checks++; if (err_o !== 1'b1 || mem_req_o !== 1'b1 || d_stall_o !== 1'b1) begin
          errors++; $display("FAIL err_hold: got err=%b req=%b stall=%b expected 1 1 1", err_o, mem_req_o, d_stall_o); end
      end
      @(posedge clk); #1;
    end
    ack_lat = 1;
    st = 0;
    forever begin
      @(negedge clk);
      if (!d_stall_o) break;
      st++;
      if (st > 20) begin errors++; $display("FAIL late_ack_timeout: got %0d cycles expected release", st); break; end
      @(posedge clk); #1;
    end
    exp = dload_q.pop_front();
    checks++; if (d_rdata_o !== exp) begin errors++; $display("FAIL late_ack_data: got %h expected %h", d_rdata_o, exp); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    $display("timeout: err=%b d_rdata=%h", err_o, d_rdata_o);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int st;
    logic [DW-1:0] exp;
    ack_lat = 0;
    @(posedge clk); #1;
    d_req_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h300;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1; d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h20;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b expected 0", mem_req_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", err_o); end
    checks++; if (mem_addr_o !== '0 || d_rdata_o !== '0 || i_data_o !== '0) begin
      errors++; $display("FAIL mid_rst_regs: got addr=%h rdata=%h idata=%h expected 0 0 0", mem_addr_o, d_rdata_o, i_data_o); end
    checks++; if (i_stall_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ibuf: got i_stall=%b expected 1", i_stall_o); end
    ack_lat = 1;
    ifetch_q.push_back(32'hDEADBEEF);
    run_access(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, st);
    exp = ifetch_q.pop_front();
    checks++; if (i_data_o !== exp || st != 1) begin
      errors++; $display("FAIL mid_rst_refetch: got %h/%0d expected %h/1", i_data_o, st, exp); end
    $display("reset mid-transaction: refetch data=%h", i_data_o);
    idle_inputs();
  endtask

  initial begin
    mem_model[32'h10]  = 32'h00A00093;
    mem_model[32'h14]  = 32'h00B00113;
    mem_model[32'h20]  = 32'h00C00193;
    mem_model[32'h100] = 32'h12345678;
    mem_model[32'h200] = 32'hCAFEF00D;
    last_rdata = '0;
    test_reset();
    test_fetch_miss();
    test_collision();
    test_store_invalidate();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
